// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port DMem: round-robin with an m1 burst lock, zero-cycle
// request-to-memory path, one-cycle response; ready depends only on arbitration, never on responses.
module dmem_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_,

   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_rsp_valid,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_rsp_valid,
   output logic [DATA_W-1:0] m1_rdata,
   input  logic              m1_lock,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              busy
);

   logic prio_q,    prio_d;
   logic locked_q,  locked_d;
   logic pend_q,    pend_d;
   logic owner_q,   owner_d;
   logic rd_q,      rd_d;

   logic m0_elig, m1_elig;
   logic grant_m0, grant_m1;
   logic accept;

   // While locked only m1 may compete; prio_q breaks ties (1 = m1 favoured).
   always_comb begin
      m0_elig  = m0_valid && !locked_q;
      m1_elig  = m1_valid;
      grant_m1 = !rst_ && m1_elig && (!m0_elig || prio_q);
      grant_m0 = !rst_ && m0_elig && !grant_m1;
      accept   = grant_m0 || grant_m1;
   end

   assign m0_ready = grant_m0;
   assign m1_ready = grant_m1;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_m1) begin
         mem_en    = 1'b1;
         mem_we    = m1_we;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
      end else if (grant_m0) begin
         mem_en    = 1'b1;
         mem_we    = m0_we;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
      end
   end

   always_comb begin
      prio_d   = prio_q;
      locked_d = locked_q;
      pend_d   = accept;
      owner_d  = owner_q;
      rd_d     = 1'b0;
      if (grant_m0) begin
         prio_d  = 1'b1;
         owner_d = 1'b0;
         rd_d    = !m0_we;
      end else if (grant_m1) begin
         prio_d  = 1'b0;
         owner_d = 1'b1;
         rd_d    = !m1_we;
      end
      // The lock is only taken on an m1 acceptance, but any cycle without m1_lock releases it.
      if (grant_m1 && m1_lock) begin
         locked_d = 1'b1;
      end else if (!m1_lock) begin
         locked_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         prio_q   <= 1'b0;
         locked_q <= 1'b0;
         pend_q   <= 1'b0;
         owner_q  <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         prio_q   <= prio_d;
         locked_q <= locked_d;
         pend_q   <= pend_d;
         owner_q  <= owner_d;
         rd_q     <= rd_d;
      end
   end

   // Write responses return zero data; the non-owner always sees zero.
   always_comb begin
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
      m0_rdata     = '0;
      m1_rdata     = '0;
      busy         = 1'b0;
      if (!rst_ && pend_q) begin
         busy = 1'b1;
         if (owner_q) begin
            m1_rsp_valid = 1'b1;
            m1_rdata     = rd_q ? mem_rdata : '0;
         end else begin
            m0_rsp_valid = 1'b1;
            m0_rdata     = rd_q ? mem_rdata : '0;
         end
      end
   end

   a_one_grant : assert property (@(posedge clk) !(m0_ready && m1_ready));
   a_lock_blocks_m0 : assert property (@(posedge clk) locked_q |-> !m0_ready);

endmodule
